hex_bcd_display_ctrl: RTL and testbench

Sequencing controller in front of a bank of per-digit seven-segment decoders (0-9, active-low segments).
- Accepts a binary value through a load handshake.
- Converts it to packed BCD with a multi-cycle shift-add-3 (double-dabble) sequence.
- Presents stable, registered digit nibbles, one per decoder instance, plus done/overflow status.
- Sits between the user datapath (counters, switches, ALU results) and the display decoders; the top level instantiates one decoder per nibble.

---
 rtl/hex_bcd_display_ctrl_pkg.sv | 24 ++
 rtl/hex_bcd_display_ctrl_adj3.sv | 11 +
 rtl/hex_bcd_display_ctrl.sv | 120 ++++++++++++
 tb/tb_hex_bcd_display_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_bcd_display_ctrl_pkg.sv
// Shared types and constants for the hex-to-BCD display controller.
// The optional lead-zero blanking is enabled by HEX_CTRL_LEAD_ZERO_BLANK_EN.
package hex_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Elaboration-time 10^n; used to build the overflow limit.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_bcd_display_ctrl_adj3.sv
// Combinational double-dabble cell: add 3 to a BCD nibble that is 5 or more.
module bcd_adj3
    import hex_ctrl_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? (din + ADJ_ADD) : din;

endmodule

// File: rtl/hex_bcd_display_ctrl.sv
// Load-handshake binary-to-BCD sequencer feeding per-digit seven-segment decoders.
// Define HEX_CTRL_LEAD_ZERO_BLANK_EN to add the registered leading-zero blank mask.
module hex_bcd_display_ctrl
    import hex_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] digits
`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   blank
`endif
);

    localparam int                SCR_W     = 4 * NUM_DIGITS;
    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam logic [31:0]       MAX_VAL   = pow10(NUM_DIGITS) - 32'd1;
    localparam logic [SCR_W-1:0]  ALL_NINES = {NUM_DIGITS{4'h9}};

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pending;
    logic               accept;
    logic [31:0]        bin_ext;

    assign accept  = (state == IDLE) && load && !busy;
    assign bin_ext = 32'(bin_in);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_adj3 u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (scratch_adj[4*g +: 4])
        );
    end

    // busy stays high through the done cycle, so a load presented alongside done is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            digits      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg       <= bin_in;
                        scratch     <= '0;
                        cnt         <= CNT_W'(BIN_W);
                        ovf_pending <= (bin_ext > MAX_VAL);
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    // The truncating cast drops the bit shifted out of the top nibble.
                    scratch <= SCR_W'({scratch_adj, shreg[BIN_W-1]});
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    digits   <= ovf_pending ? ALL_NINES : scratch;
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_next;
    logic                  zero_above;

    // Walk down from the top digit; the ones digit is never blanked.
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (scratch[4*i +: 4] == 4'd0);
            blank_next[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank <= '0;
        end else if (state == DONE) begin
            blank <= ovf_pending ? '0 : blank_next;
        end
    end
`endif

endmodule

// File: tb/tb_hex_bcd_display_ctrl.sv
// Self-checking bench for hex_bcd_display_ctrl: arithmetic reference model plus directed and random loads.
module tb_hex_bcd_display_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int LAT        = BIN_W + 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    load = 1'b0;
    logic [BIN_W-1:0]        bin_in = '0;
    logic                    busy, done, overflow;
    logic [4*NUM_DIGITS-1:0] digits;
`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]   blank;
`endif

    int vectors = 0;
    int miscompares = 0;

    hex_bcd_display_ctrl #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digits   (digits)
`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain decimal arithmetic and a remaining-cycles countdown.
    bit                      m_valid = 1'b0;
    bit                      m_busy, m_done, m_ovf;
    int                      m_rem;
    longint                  m_val;
    logic [4*NUM_DIGITS-1:0] m_digits;
    logic [NUM_DIGITS-1:0]   m_blank;

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*NUM_DIGITS-1:0] toBcd(input longint v);
        logic [4*NUM_DIGITS-1:0] r;
        longint t = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_rem    = 0;
            m_digits = '0;
            m_blank  = '0;
        end else if (m_valid) begin
            if (m_busy && m_done) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done   = 1'b1;
                    m_ovf    = (m_val > pow10(NUM_DIGITS) - 1);
                    m_digits = m_ovf ? {NUM_DIGITS{4'h9}} : toBcd(m_val);
                    m_blank  = '0;
                    for (int i = 1; i < NUM_DIGITS; i++)
                        m_blank[i] = !m_ovf && (m_val < pow10(i));
                end
            end else if (load) begin
                m_busy = 1'b1;
                m_rem  = LAT;
                m_val  = longint'(bin_in);
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("busy", longint'(busy), longint'(m_busy));
            checkOutput("done", longint'(done), longint'(m_done));
            checkOutput("overflow", longint'(overflow), longint'(m_ovf));
            checkOutput("digits", longint'(digits), longint'(m_digits));
`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
            checkOutput("blank", longint'(blank), longint'(m_blank));
`endif
        end
    end

    // Presents one load cycle and returns at the negedge right after the sampling edge.
    task automatic applyStimulus(input longint value);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        load   = 1'b1;
        bin_in = BIN_W'(value);
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
        end
    endtask

    task automatic countDones(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        longint picks [6] = '{0, 1, 9999, 10000, 16383, 999};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_digits", longint'(digits), 0);
        checkOutput("reset_busy", longint'(busy), 0);

        applyStimulus(0);
        waitDone(n);
        checkOutput("zero_latency", n, 15);
        checkOutput("zero_digits", longint'(digits), 64'h0000);
        checkOutput("zero_ovf", longint'(overflow), 0);
`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
        checkOutput("zero_blank", longint'(blank), 4'b1110);
`endif

        applyStimulus(1234);
        waitDone(n);
        checkOutput("d1234_latency", n, 15);
        checkOutput("d1234_digits", longint'(digits), 64'h1234);

        applyStimulus(9999);
        waitDone(n);
        checkOutput("d9999_digits", longint'(digits), 64'h9999);
        checkOutput("d9999_ovf", longint'(overflow), 0);

        applyStimulus(10000);
        waitDone(n);
        checkOutput("d10000_digits", longint'(digits), 64'h9999);
        checkOutput("d10000_ovf", longint'(overflow), 1);

        applyStimulus(42);
        repeat (5) @(negedge clk);
        load   = 1'b1;
        bin_in = BIN_W'(77);
        @(negedge clk);
        load   = 1'b0;
        waitDone(n);
        checkOutput("d42_digits", longint'(digits), 64'h0042);
        checkOutput("d42_ovf", longint'(overflow), 0);
`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
        checkOutput("d42_blank", longint'(blank), 4'b1100);
`endif
        countDones(25, pulses);
        checkOutput("d42_single_done", pulses, 0);

        applyStimulus(5678);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", longint'(busy), 0);
        checkOutput("abort_digits", longint'(digits), 0);
        countDones(25, pulses);
        checkOutput("abort_no_done", pulses, 0);
        applyStimulus(5678);
        waitDone(n);
        checkOutput("d5678_digits", longint'(digits), 64'h5678);

`ifdef HEX_CTRL_LEAD_ZERO_BLANK_EN
        applyStimulus(1000);
        waitDone(n);
        checkOutput("d1000_blank", longint'(blank), 4'b0000);
        applyStimulus(12000);
        waitDone(n);
        checkOutput("d12000_blank", longint'(blank), 4'b0000);
        checkOutput("d12000_ovf", longint'(overflow), 1);
`endif

        // Random phase: loads hammered every few cycles, boundary values mixed in, rare resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 3) == 0);
            bin_in = ($urandom_range(0, 3) == 0) ? BIN_W'(picks[$urandom_range(0, 5)])
                                                 : BIN_W'($urandom);
            reset  = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
